mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter and access sequencer for the core's shared main memory: it accepts instruction-fetch and load/store requests and drives one registered access per cycle onto the memory port. Responses are returned two cycles after grant. Load/store has priority over fetch, with an optional starvation guard for fetch. It sits between the fetch unit / LSU and the main memory instance in the core top level.

## Interface
- STARVE_LIMIT, 4, consecutive denied fetch cycles after which fetch wins one arbitration (1..15)
- `XLEN (from define.sv), data/address width; not overridable per instance

- clk  in  1  core clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  XLEN  fetch address (word index into memory)
- if_flush  in  1  discard in-flight fetch responses and deny fetch this cycle
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch response valid (one-cycle pulse)
- if_rdata  out  XLEN  fetched instruction
- ls_req  in  1  load/store request; held with stable fields until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  XLEN  data address
- ls_wdata  in  XLEN  store data
- ls_gnt  out  1  load/store accepted this cycle (combinational)
- ls_rvalid  out  1  load data / store acknowledge (one-cycle pulse)
- ls_rdata  out  XLEN  load data; 0 on store acknowledge
- mem_read_en  out  1  memory read strobe (registered)
- mem_write_en  out  1  memory write strobe (registered)
- mem_addr  out  XLEN  memory address, wired to both memory address inputs
- mem_wdata  out  XLEN  memory write data
- mem_rdata  in  XLEN  memory read data, combinational from mem_addr

## Operation
- Three stages: GRANT (combinational), ACCESS (registered request), RESP (registered response). One new grant is allowed per cycle; stages are fully pipelined, with no back-pressure on responses.
- Arbitration in GRANT:
  - ls_req alone → ls_gnt.
  - if_req alone and !if_flush → if_gnt.
  - Both requesting → ls wins, unless the starve guard fires (see Configuration).
  - At most one gnt is high in any cycle.
- On grant, the ACCESS register loads {valid, src, we, addr, wdata}.
- ACCESS valid:
  - mem_read_en = !we, mem_write_en = we, mem_addr/mem_wdata from the register.
  - mem_rdata is sampled into the RESP register at the end of the cycle.
- ACCESS idle: mem_read_en = mem_write_en = 0, mem_addr/mem_wdata hold their last values.
- RESP valid: pulses if_rvalid or ls_rvalid according to src. rdata holds until the next response of the same source.
- Store acknowledge: ls_rvalid = 1, ls_rdata = 0. The memory write occurs on the clock edge ending the ACCESS cycle, so a load granted the cycle after a store to the same address returns the new data.
- if_flush: a fetch in ACCESS or RESP is marked dead and its if_rvalid is suppressed. ls traffic is unaffected.
- Reset (rst = 1 at posedge):
  - ACCESS and RESP invalid; starve counter = 0.
  - All rdata = 0; mem_addr = mem_wdata = 0.
  - While rst is high: gnts forced 0, mem_write_en forced 0. A store in ACCESS during the reset cycle is not written.

## Timing
- Grant cycle G: gnt is combinational from req/flush/counter in the same cycle.
- G+1: mem strobes asserted.
- G+2: rvalid pulse. Latency is 2 cycles, throughput is 1 access/cycle.
- Reset values: if_gnt = ls_gnt = if_rvalid = ls_rvalid = mem_read_en = mem_write_en = 0; all data outputs 0.
- A requester dropping req without a gnt is legal; nothing is recorded.
- Back-to-back grants to the same source are legal; responses return in grant order.

## Configuration
- MEM_ARB_STARVE_EN:
  - Defined:
    - A counter (width for 0..STARVE_LIMIT, saturating) increments each cycle if_req && !if_flush && ls_gnt, and clears on if_gnt, on !if_req, and on rst.
    - When counter == STARVE_LIMIT and both request, fetch wins and the counter clears.
  - Undefined: no counter; ls has strict priority and fetch can starve indefinitely.

## Test plan
- Single fetch: if_req, if_addr = 5, mem[5] = 0x00A00093 → if_gnt in cycle 0; mem_read_en/mem_addr = 5 in cycle 1; if_rvalid with if_rdata = 0x00A00093 in cycle 2.
- Store then load: store ls_addr = 8, ls_wdata = 0xDEADBEEF in cycle 0, load addr 8 in cycle 1 → ls_rvalid with rdata 0 in cycle 2; ls_rvalid with 0xDEADBEEF in cycle 3.
- Contention: if_req and ls_req held high continuously, ls_req never dropping.
  - With MEM_ARB_STARVE_EN and STARVE_LIMIT = 4: ls granted cycles 0–3, fetch in cycle 4, ls in cycles 5–8, fetch in cycle 9.
  - Without the macro: fetch is never granted.
- Flush: fetch granted in cycle 0, if_flush = 1 in cycle 1 → no if_rvalid in cycle 2; a fetch requested during the flush cycle gets no gnt.
- Reset mid-store: store granted in cycle 0, rst = 1 in cycle 1 → mem_write_en = 0, memory unchanged, no ls_rvalid, all outputs 0 in cycle 2.

Source files
------------

// File: rtl/mem_arbiter.sv
// Fetch vs. load/store arbiter: one registered memory access per cycle, responses two cycles after grant.
// Define MEM_ARB_STARVE_EN to let fetch win one arbitration after STARVE_LIMIT consecutive denials.
`ifndef XLEN
`define XLEN 32
`endif

module mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [`XLEN-1:0]  if_addr,
   input  logic              if_flush,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [`XLEN-1:0]  if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [`XLEN-1:0]  ls_addr,
   input  logic [`XLEN-1:0]  ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [`XLEN-1:0]  ls_rdata,
   output logic              mem_read_en,
   output logic              mem_write_en,
   output logic [`XLEN-1:0]  mem_addr,
   output logic [`XLEN-1:0]  mem_wdata,
   input  logic [`XLEN-1:0]  mem_rdata
);
   localparam int W = `XLEN;

   typedef enum logic {SRC_IF = 1'b0, SRC_LS = 1'b1} src_t;

   logic          acc_v;
   src_t          acc_src;
   logic          acc_we;
   logic [W-1:0]  acc_addr;
   logic [W-1:0]  acc_wdata;
   logic          if_resp_v;
   logic          ls_resp_v;
   logic          if_ok;
   logic          starve_fire;

`ifdef MEM_ARB_STARVE_EN
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   logic [CW-1:0] starve_cnt;

   assign starve_fire = (starve_cnt == CW'(STARVE_LIMIT));

   // Counts cycles a live fetch lost to load/store; a flushed fetch neither counts nor clears.
   always_ff @(posedge clk) begin
      if (rst || if_gnt || !if_req)
         starve_cnt <= '0;
      else if (!if_flush && ls_gnt && !starve_fire)
         starve_cnt <= starve_cnt + 1'b1;
   end
`else
   assign starve_fire = 1'b0;
`endif

   assign if_ok  = if_req && !if_flush && !rst;
   assign ls_gnt = ls_req && !rst && !(if_ok && starve_fire);
   assign if_gnt = if_ok && (!ls_req || starve_fire);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_v     <= 1'b0;
         acc_src   <= SRC_IF;
         acc_we    <= 1'b0;
         acc_addr  <= '0;
         acc_wdata <= '0;
      end else begin
         acc_v <= if_gnt || ls_gnt;
         if (ls_gnt) begin
            acc_src   <= SRC_LS;
            acc_we    <= ls_we;
            acc_addr  <= ls_addr;
            acc_wdata <= ls_wdata;
         end else if (if_gnt) begin
            acc_src  <= SRC_IF;
            acc_we   <= 1'b0;
            acc_addr <= if_addr;
         end
      end
   end

   // A fetch flushed while in ACCESS never reaches RESP; one flushed in RESP is masked below.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_resp_v <= 1'b0;
         ls_resp_v <= 1'b0;
         if_rdata  <= '0;
         ls_rdata  <= '0;
      end else begin
         if_resp_v <= acc_v && (acc_src == SRC_IF) && !if_flush;
         ls_resp_v <= acc_v && (acc_src == SRC_LS);
         if (acc_v && (acc_src == SRC_IF) && !if_flush)
            if_rdata <= mem_rdata;
         if (acc_v && (acc_src == SRC_LS))
            ls_rdata <= acc_we ? '0 : mem_rdata;
      end
   end

   assign if_rvalid    = if_resp_v && !if_flush;
   assign ls_rvalid    = ls_resp_v;
   assign mem_read_en  = acc_v && !acc_we;
   assign mem_write_en = acc_v && acc_we && !rst;
   assign mem_addr     = acc_addr;
   assign mem_wdata    = acc_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a grant-history reference model plus directed literal checks.
// Follows MEM_ARB_STARVE_EN the same way the design does.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_arbiter;
   localparam int W = `XLEN;
   localparam int L = 4;
   localparam int N = 4096;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, if_req, if_flush, ls_req, ls_we;
   logic [W-1:0] if_addr, ls_addr, ls_wdata;
   logic if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_read_en, mem_write_en;
   logic [W-1:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;

   int total = 0;
   int bad = 0;

   mem_arbiter #(.STARVE_LIMIT(L)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   function automatic logic [W-1:0] init_val(int i);
      if (i == 5) return W'(32'h00A00093);
      return W'((i * 32'h9E3779B9) ^ 32'h13572468);
   endfunction

   // Memory environment: combinational read, write on the edge ending the access cycle.
   logic [W-1:0] mem [256];
   bit mem_init = 1'b0;
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
         mem_init <= 1'b1;
      end else if (mem_write_en) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr[7:0]];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t got=%h want=%h", nm, $time, act, exp);
      end
   endtask

   // Reference model: per-cycle grant history; access = grant of t-1, response = grant of t-2.
   logic [W-1:0] ref_mem [256];
   int           h_g   [N];
   bit           h_we  [N];
   bit           h_rst [N];
   bit           h_fl  [N];
   logic [W-1:0] h_addr[N];
   logic [W-1:0] h_wd  [N];
   logic [W-1:0] h_data[N];
   int           cyc = 0;
   int           m_cnt = 0;
   logic [W-1:0] last_addr = '0;
   bit           known = 1'b0;

   // 0 = no grant, 1 = fetch, 2 = load/store
   function automatic int exp_g();
      bit fire;
`ifdef MEM_ARB_STARVE_EN
      fire = (m_cnt == L);
`else
      fire = 1'b0;
`endif
      if (rst) return 0;
      if (ls_req && !(fire && if_req && !if_flush)) return 2;
      if (if_req && !if_flush) return 1;
      return 0;
   endfunction

   always @(posedge clk) begin
      int g, a;
      logic [W-1:0] ga;
      if (cyc == 0)
         for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      g  = exp_g();
      ga = (g == 2) ? ls_addr : if_addr;
      if (cyc < N) begin
         h_g[cyc]    = g;
         h_rst[cyc]  = rst;
         h_fl[cyc]   = if_flush;
         h_we[cyc]   = (g == 2) && ls_we;
         h_addr[cyc] = ga;
         h_wd[cyc]   = ls_wdata;
      end
      a = cyc - 1;
      if (a >= 0 && a < N && h_g[a] != 0) begin
         if (h_we[a]) begin
            if (!rst) ref_mem[h_addr[a][7:0]] = h_wd[a];
         end else begin
            h_data[a] = ref_mem[h_addr[a][7:0]];
         end
      end
      if (rst) last_addr = '0;
      else if (g != 0) last_addr = ga;
      if (rst || g == 1 || !if_req) m_cnt = 0;
      else if (!if_flush && g == 2 && m_cnt < L) m_cnt++;
      if (rst) known = 1'b1;
      cyc++;
   end

   always @(negedge clk) begin
      int t, g, p, q;
      bit acc, r, eif;
      t = cyc;
      if (known && t >= 2 && t < N) begin
         g = exp_g();
         chk("if_gnt", W'(if_gnt), W'(g == 1));
         chk("ls_gnt", W'(ls_gnt), W'(g == 2));
         p   = t - 1;
         acc = (h_g[p] != 0);
         chk("mem_read_en", W'(mem_read_en), W'(acc && !h_we[p]));
         chk("mem_write_en", W'(mem_write_en), W'(acc && h_we[p] && !rst));
         chk("mem_addr", mem_addr, last_addr);
         if (acc && h_we[p]) chk("mem_wdata", mem_wdata, h_wd[p]);
         q   = t - 2;
         r   = (h_g[q] != 0) && !h_rst[t-1];
         eif = r && (h_g[q] == 1) && !h_fl[t-1] && !if_flush;
         chk("if_rvalid", W'(if_rvalid), W'(eif));
         chk("ls_rvalid", W'(ls_rvalid), W'(r && h_g[q] == 2));
         if (eif) chk("if_rdata", if_rdata, h_data[q]);
         if (r && h_g[q] == 2) chk("ls_rdata", ls_rdata, h_we[q] ? '0 : h_data[q]);
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_req = 1'b0; ls_req = 1'b0; if_flush = 1'b0; ls_we = 1'b0;
   endtask

   initial begin
      logic [9:0] pat;
      bit gi, gl;
      rst = 1'b1; idle();
      if_addr = '0; ls_addr = '0; ls_wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_strobes", W'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_read_en, mem_write_en}), '0);
      chk("rst_if_rdata", if_rdata, '0);
      chk("rst_ls_rdata", ls_rdata, '0);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_mem_wdata", mem_wdata, '0);

      // single fetch
      nxt(); if_req = 1'b1; if_addr = 5;
      @(negedge clk); chk("fetch_gnt", W'(if_gnt), W'(1));
      nxt(); idle();
      @(negedge clk); chk("fetch_rd_en", W'(mem_read_en), W'(1)); chk("fetch_addr", mem_addr, W'(5));
      nxt();
      @(negedge clk); chk("fetch_rvalid", W'(if_rvalid), W'(1)); chk("fetch_rdata", if_rdata, W'(32'h00A00093));

      // store then load, same address
      nxt(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8; ls_wdata = W'(32'hDEADBEEF);
      @(negedge clk); chk("st_gnt", W'(ls_gnt), W'(1));
      nxt(); ls_we = 1'b0;
      @(negedge clk); chk("ld_gnt", W'(ls_gnt), W'(1));
      nxt(); idle();
      @(negedge clk); chk("st_ack", W'(ls_rvalid), W'(1)); chk("st_ack_data", ls_rdata, '0);
      nxt();
      @(negedge clk); chk("ld_rvalid", W'(ls_rvalid), W'(1)); chk("ld_data", ls_rdata, W'(32'hDEADBEEF));

      // contention with both requests held
      nxt(); idle();
      pat = '0;
      for (int c = 0; c < 10; c++) begin
         nxt(); if_req = 1'b1; if_addr = 41; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 40;
         @(negedge clk); pat[c] = if_gnt;
      end
`ifdef MEM_ARB_STARVE_EN
      chk("starve_pattern", W'(pat), W'(10'b1000010000));
`else
      chk("starve_pattern", W'(pat), '0);
`endif
      nxt(); idle();
      repeat (2) nxt();

      // flush kills an in-flight fetch and denies a new one
      nxt(); if_req = 1'b1; if_addr = 6;
      @(negedge clk); chk("fl_gnt0", W'(if_gnt), W'(1));
      nxt(); if_flush = 1'b1; if_addr = 7;
      @(negedge clk); chk("fl_gnt1", W'(if_gnt), W'(0));
      nxt(); idle();
      @(negedge clk); chk("fl_rvalid", W'(if_rvalid), W'(0));
      repeat (2) nxt();

      // reset while a store sits in ACCESS
      nxt(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 20; ls_wdata = W'(32'h55AA55AA);
      @(negedge clk); chk("rs_gnt", W'(ls_gnt), W'(1));
      nxt(); idle(); rst = 1'b1;
      @(negedge clk); chk("rs_wr_en", W'(mem_write_en), W'(0));
      nxt(); rst = 1'b0;
      @(negedge clk);
      chk("rs_strobes", W'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_read_en, mem_write_en}), '0);
      chk("rs_data", if_rdata | ls_rdata | mem_addr | mem_wdata, '0);
      chk("rs_mem", mem[20], init_val(20));
      repeat (2) nxt();

      // randomized traffic
      gi = 1'b0; gl = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         nxt();
         rst      = ($urandom_range(0, 99) == 0);
         if_flush = ($urandom_range(0, 7) == 0);
         if (!if_req || gi || $urandom_range(0, 7) == 0) begin
            if_req  = ($urandom_range(0, 1) == 1);
            if_addr = W'($urandom_range(0, 255));
         end
         if (!ls_req || gl || $urandom_range(0, 7) == 0) begin
            ls_req   = ($urandom_range(0, 9) < 7);
            ls_we    = ($urandom_range(0, 1) == 1);
            ls_addr  = W'($urandom_range(0, 255));
            ls_wdata = W'($urandom);
         end
         @(negedge clk);
         gi = if_gnt; gl = ls_gnt;
      end
      nxt(); idle(); rst = 1'b0;
      repeat (4) nxt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
